// File: rtl/lae_feeder.sv
// lae_feeder: host-side session sequencer for the lightweight authenticated-encryption
// core. It drives start/Ain/Min/last into lae_control and follows its getdata/final_o.
// Ports: ck, rst (sync, active-high); req/ad_len/msg_len session request;
//   blk_valid/blk_ready upstream block handshake; getdata/init/final_o from control;
//   start/Ain/Min/last to control; hold datapath freeze; busy/done/err status.
// Option: define LAE_FEEDER_TIMEOUT_EN for a FIN watchdog of TMO cycles (sets err).
module lae_feeder #(
  parameter int LW  = 8,
  parameter int TMO = 20
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          req,
  input  logic [LW-1:0] ad_len,
  input  logic [LW-1:0] msg_len,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic          getdata,
  input  logic          init,
  input  logic          final_o,
  output logic          start,
  output logic          Ain,
  output logic          Min,
  output logic          last,
  output logic          hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WINIT = 3'd2;
  localparam logic [2:0] S_AD    = 3'd3;
  localparam logic [2:0] S_MSG   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    st_q, st_d;
  logic [LW-1:0] ad_q, ad_d;
  logic [LW-1:0] msg_q, msg_d;

  // init carries no information the sequencer needs; getdata marks init end.
  logic init_unused;
  assign init_unused = init;

  // The first getdata cycle is seen while still in WINIT; absorption starts in
  // that same cycle, so WINIT behaves like the phase it is about to enter.
  logic ph_ad, ph_msg, absorb, take;
  assign ph_ad  = (st_q == S_AD) ||
                  ((st_q == S_WINIT) && (ad_q != '0));
  assign ph_msg = (st_q == S_MSG) ||
                  ((st_q == S_WINIT) && (ad_q == '0) && (msg_q != '0));
  assign absorb = getdata && (ph_ad || ph_msg);
  assign take   = absorb && blk_valid;

  assign blk_ready = take;
  assign Ain       = take && ph_ad;
  assign Min       = take && ph_msg;
  assign hold      = absorb && !blk_valid;
  assign start     = (st_q == S_START);
  assign last      = (st_q == S_FIN);
  assign done      = (st_q == S_DONE);
  assign busy      = (st_q != S_IDLE);

`ifdef LAE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TMO - 1));
  assign err     = err_q;
`else
  localparam int TMO_UNUSED = TMO;
  logic tmo_hit;
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    st_d  = st_q;
    ad_d  = ad_q;
    msg_d = msg_q;
`ifdef LAE_FEEDER_TIMEOUT_EN
    err_d = err_q;
    tmo_d = (st_q == S_FIN) ? tmo_q + 1'b1 : '0;
`endif
    unique case (st_q)
      S_IDLE: begin
        if (req) begin
          ad_d  = ad_len;
          msg_d = msg_len;
          st_d  = S_START;
`ifdef LAE_FEEDER_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end
      end
      S_START: st_d = S_WINIT;
      S_WINIT, S_AD, S_MSG: begin
        if (getdata) begin
          if (ph_ad) begin
            st_d = S_AD;
            if (take) begin
              ad_d = ad_q - 1'b1;
              if (ad_q == LW'(1))
                st_d = (msg_q != '0) ? S_MSG : S_FIN;
            end
          end else if (ph_msg) begin
            st_d = S_MSG;
            if (take) begin
              msg_d = msg_q - 1'b1;
              if (msg_q == LW'(1))
                st_d = S_FIN;
            end
          end else begin
            st_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        if (final_o) begin
          st_d = S_DONE;
        end else if (tmo_hit) begin
          st_d = S_IDLE;
`ifdef LAE_FEEDER_TIMEOUT_EN
          err_d = 1'b1;
`endif
        end
      end
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      st_q  <= S_IDLE;
      ad_q  <= '0;
      msg_q <= '0;
`ifdef LAE_FEEDER_TIMEOUT_EN
      err_q <= 1'b0;
      tmo_q <= '0;
`endif
    end else begin
      st_q  <= st_d;
      ad_q  <= ad_d;
      msg_q <= msg_d;
`ifdef LAE_FEEDER_TIMEOUT_EN
      err_q <= err_d;
      tmo_q <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_lae_feeder.sv
// tb_lae_feeder: randomized session bench for lae_feeder with a
// transaction-level model of the block stream and control-FSM timing.
module tb_lae_feeder;
  localparam int LW  = 8;
  localparam int TMO = 20;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [LW-1:0] ad_len = '0;
  logic [LW-1:0] msg_len = '0;
  logic          blk_valid = 1'b0;
  logic          getdata = 1'b0;
  logic          init = 1'b0;
  logic          final_o = 1'b0;
  logic blk_ready, start, Ain, Min, last, hold, busy, done, err;

  int n_chk = 0;
  int n_err = 0;

  int mon = 0;
  int n_rdy, n_hold, n_start, n_done, n_ab;

  lae_feeder #(.LW(LW), .TMO(TMO)) dut (
    .ck(ck), .rst(rst), .req(req), .ad_len(ad_len),
    .msg_len(msg_len), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .getdata(getdata), .init(init),
    .final_o(final_o), .start(start), .Ain(Ain), .Min(Min),
    .last(last), .hold(hold), .busy(busy), .done(done),
    .err(err)
  );

  always #5 ck = ~ck;

  always @(negedge ck) begin
    if (mon != 0) begin
      n_rdy   += int'(blk_ready);
      n_hold  += int'(hold);
      n_start += int'(start);
      n_done  += int'(done);
      n_ab    += int'(Ain & Min);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete session. The model is a queue of expected block kinds
  // (1 = AD, 2 = message); control timing is the bench's own schedule.
  task automatic session(input int ad, input int msg,
                         input bit rnd, input int st_idx,
                         input int st_n, input bit poke,
                         input bit wd);
    int q[$];
    int popped = 0;
    int stl = 0;
    int exp_hold = 0;
    int guard = 0;
    logic [31:0] r;
    for (int i = 0; i < ad; i++) q.push_back(1);
    for (int i = 0; i < msg; i++) q.push_back(2);
    n_rdy = 0; n_hold = 0; n_start = 0; n_done = 0; n_ab = 0;
    mon = 1;
    @(posedge ck); #1;
    req = 1'b1; ad_len = ad[LW-1:0]; msg_len = msg[LW-1:0];
    getdata = 1'b0; final_o = 1'b0; blk_valid = 1'b0;
    @(negedge ck);
    chk("idle_busy", busy, 0);
    chk("idle_start", start, 0);
    @(posedge ck); #1;
    req = 1'b0;
    @(negedge ck);
    chk("start", start, 1);
    chk("busy", busy, 1);
    chk("err_clr", err, 0);
    for (int i = 1; i <= 16; i++) begin
      @(posedge ck); #1;
      init = (i == 1);
      req = poke && (i == 3);
      if (req) begin
        r = $urandom;
        ad_len = r[7:0];
        msg_len = r[15:8];
      end
      blk_valid = 1'($urandom_range(0, 1));
      @(negedge ck);
      if (i == 16) chk("init_last", last, 0);
    end
    do begin
      @(posedge ck); #1;
      getdata = 1'b1;
      init = 1'b0;
      if (q.size() == 0)
        blk_valid = 1'($urandom_range(0, 1));
      else if (rnd)
        blk_valid = ($urandom_range(0, 3) != 0);
      else if (popped == st_idx && stl < st_n) begin
        blk_valid = 1'b0;
        stl++;
      end else
        blk_valid = 1'b1;
      @(negedge ck);
      chk("abs_last", last, 0);
      if (q.size() == 0) begin
        chk("empty_rdy", blk_ready, 0);
        chk("empty_hold", hold, 0);
      end else if (blk_valid) begin
        chk("ready", blk_ready, 1);
        chk("ain", Ain, q[0] == 1);
        chk("min", Min, q[0] == 2);
        chk("no_hold", hold, 0);
        void'(q.pop_front());
        popped++;
      end else begin
        chk("hold", hold, 1);
        chk("stall_rdy", blk_ready, 0);
        chk("stall_cmd", {Ain, Min}, 0);
        exp_hold++;
      end
      guard++;
    end while (q.size() > 0 && guard < 4000);
    if (guard >= 4000) chk("absorb_bound", 0, 1);
`ifdef LAE_FEEDER_TIMEOUT_EN
    if (wd) begin
      for (int k = 0; k <= TMO; k++) begin
        @(posedge ck); #1;
        getdata = 1'b0; final_o = 1'b0;
        @(negedge ck);
        if (k < TMO) begin
          chk("wd_last", last, 1);
        end else begin
          chk("wd_last_drop", last, 0);
          chk("wd_err", err, 1);
          chk("wd_busy", busy, 0);
        end
      end
    end else
`endif
    begin
      for (int k = 0; k <= 15; k++) begin
        @(posedge ck); #1;
        getdata = 1'b0;
        blk_valid = 1'($urandom_range(0, 1));
        final_o = (k == 15);
        @(negedge ck);
        chk(k == 0 ? "last_rise" : "last_held", last, 1);
      end
      @(posedge ck); #1;
      final_o = 1'b0;
      req = 1'b1;
      r = $urandom;
      ad_len = r[7:0];
      msg_len = r[15:8];
      @(negedge ck);
      chk("done", done, 1);
      chk("done_last", last, 0);
      chk("err_zero", err, 0);
      @(posedge ck); #1;
      req = 1'b0;
      @(negedge ck);
      chk("post_busy", busy, 0);
      chk("post_start", start, 0);
      chk("post_done", done, 0);
    end
    #1;
    mon = 0;
    chk("n_ready", n_rdy, ad + msg);
    chk("n_hold", n_hold, exp_hold);
    chk("n_start", n_start, 1);
    chk("n_done", n_done, wd ? 0 : 1);
    chk("ain_min_excl", n_ab, 0);
  endtask

  initial begin
    repeat (2) @(posedge ck);
    @(negedge ck);
    chk("rst_outs", {blk_ready, start, Ain, Min, last,
                     hold, busy, done, err}, 0);
    @(posedge ck); #1;
    rst = 1'b0;
    @(negedge ck);
    chk("idle_outs", {blk_ready, start, Ain, Min, last,
                      hold, busy, done, err}, 0);

    session(2, 3, 0, -1, 0, 0, 0);
    session(0, 0, 0, -1, 0, 0, 0);
    session(0, 4, 0, 1, 3, 0, 0);
    session(3, 2, 0, -1, 0, 1, 0);
    session(255, 1, 1, -1, 0, 0, 0);
    session(0, 255, 0, -1, 0, 0, 0);

    // Reset in the middle of the second AD block.
    @(posedge ck); #1;
    req = 1'b1; ad_len = 8'd3; msg_len = 8'd2; blk_valid = 1'b0;
    @(posedge ck); #1;
    req = 1'b0;
    repeat (16) @(posedge ck);
    @(posedge ck); #1;
    getdata = 1'b1; blk_valid = 1'b1;
    @(posedge ck); #1;
    rst = 1'b1;
    @(negedge ck);
    chk("rst_cyc_ain", Ain, 1);
    @(posedge ck); #1;
    rst = 1'b0;
    @(negedge ck);
    chk("rst_mid_outs", {blk_ready, start, Ain, Min, last,
                         hold, busy, done, err}, 0);
    @(posedge ck); #1;
    getdata = 1'b0; blk_valid = 1'b0;
    session(2, 2, 1, -1, 0, 0, 0);

    for (int r = 0; r < 10; r++)
      session($urandom_range(0, 6), $urandom_range(0, 6), 1, -1, 0,
              1'($urandom_range(0, 1)), 0);

`ifdef LAE_FEEDER_TIMEOUT_EN
    session(1, 1, 0, -1, 0, 0, 1);
    session(1, 2, 1, -1, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
